uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of uart_tx.
- Samples an asynchronous serial line with an oversampled clock and recovers 8N1 frames, LSB first.
- Pushes each good byte into a downstream sink, a FIFO or consumer, using a put/full handshake.
- Drives an active-low rts to pace the remote transmitter, matching the cts convention on uart_tx.

Parameters:
- OVERSAMPLE, 16, clock ticks per bit. Must be even and ≥4.
- DATA_BITS, 8, data bits per frame. Width of out.

Ports:
- clock  input  1  oversample clock, OVERSAMPLE × baud
- reset  input  1  asynchronous, active-high
- rx  input  1  serial line; idles high; asynchronous to clock
- out  output  DATA_BITS  received byte; valid while put=1
- put  output  1  one-clock write strobe to the sink
- full  input  1  sink cannot accept a byte
- rts  output  1  active-low ready-to-send; 0 means the remote may transmit
- frame_error  output  1  one-clock pulse: stop bit sampled low
- overrun  output  1  one-clock pulse: good byte dropped because full=1

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - state=IDLE, out=0, put=0, frame_error=0, overrun=0, rts=1.
  - Both synchronizer flops are set to 1.
  - Counter and bit index are cleared.
  - An asserted reset aborts any frame in progress; no strobes are generated.
- Input synchronizer: 2-flop chain, rx → rxs. All decisions use rxs only.
- rts is registered from full: rts <= full each clock.
- Counter cnt is wide enough for OVERSAMPLE; bit index bi is wide enough for DATA_BITS.
- IDLE:
  - If rxs=0: go to START, cnt<=1.
- START:
  - If cnt==OVERSAMPLE/2 (mid start bit):
    - rxs=0: go to DATA, cnt<=1, bi<=0.
    - rxs=1: treat as a glitch, return to IDLE, no strobe.
  - Otherwise cnt<=cnt+1.
- DATA:
  - If cnt==OVERSAMPLE: shift rxs into the MSB of the shift register (LSB-first line order), cnt<=1, bi<=bi+1.
  - After the DATA_BITS-th sample: go to STOP.
  - Otherwise cnt<=cnt+1.
- STOP:
  - If cnt==OVERSAMPLE (mid stop bit):
    - rxs=1 and full=0: out<=shift register, put<=1, go to IDLE.
    - rxs=1 and full=1: overrun<=1, out unchanged, byte dropped, go to IDLE.
    - rxs=0: frame_error<=1, byte dropped, go to BREAK.
  - Otherwise cnt<=cnt+1.
- BREAK:
  - Stay until rxs=1, then go to IDLE. This prevents a held-low line (break) from being read as repeated frames.
- Strobes: put, frame_error and overrun are registered, high for exactly one clock, and mutually exclusive.
- full is sampled only on the stop-sample clock. out holds its value until the next put.
- Timing, counted from the clock edge at which IDLE first sees rxs=0:
  - Start sample at +OVERSAMPLE/2.
  - Data bit k sampled at +OVERSAMPLE/2 + (k+1)·OVERSAMPLE.
  - Stop sample at +OVERSAMPLE/2 + (DATA_BITS+1)·OVERSAMPLE, which is 152 with defaults.
  - put is high in the following cycle.
  - Pin-to-detection adds 2–3 clocks from the synchronizer.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so a start bit immediately after the stop bit is detected. No idle gap is required.
- Baud tolerance: a mid-bit sample per bit tolerates about ±4% cumulative mismatch at the defaults.

Test Plan:
- Single byte: drive frame 0x48 at 16 clocks/bit, full=0 → exactly one put pulse, out=8'h48, 152 clocks after detection; frame_error=0, overrun=0.
- Back-to-back stream: frames 48 65 6C 6C 6F 0D 0A with no idle gap → seven put pulses with bytes in that order, no error pulses.
- Start-bit glitch: rx low for 4 clocks, then high → no put, no frame_error, back in IDLE. A following valid 0x55 frame is received correctly.
- Framing error: frame 0xA5 with stop bit 0, line then held low for 40 bit times and released → exactly one frame_error pulse, no put. The next valid 0x3C frame gives out=8'h3C.
- Overrun and flow control:
  - Hold full=1 and send 0x61 → one overrun pulse, no put, out keeps its previous value.
  - rts=1 one clock after full rises; rts=0 one clock after full falls.
  - Resend 0x61 with full=0 → put, out=8'h61.
- Reset mid-frame: assert reset during data bit 3 of 0x7E → put, frame_error, overrun and out go to 0 and rts goes to 1 at once. After release, no strobe comes from the aborted frame, and a fresh 0x7E frame gives put with out=8'h7E.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: sink-side bundle between the UART receiver and whatever
// consumes its bytes (a FIFO or a direct consumer).
//   out  - received byte, valid while put is high, held until the next put
//   put  - one-clock write strobe toward the sink
//   full - sink cannot accept a byte this cycle
//   rts  - active-low ready-to-send, registered copy of full, forwarded to
//          the remote transmitter so it can pause
// master = receiver side, slave = sink side.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] out;
  logic                 put;
  logic                 full;
  logic                 rts;

  modport master (
    output out,
    output put,
    output rts,
    input  full
  );

  modport slave (
    input  out,
    input  put,
    input  rts,
    output full
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver for N-data-bit, no-parity, one-stop
// frames, LSB first.  Every good byte is pushed into the sink through a
// put/full handshake, and rts tells the remote transmitter to pause.
//   clock       - oversample clock, OVERSAMPLE x baud
//   reset       - asynchronous, active-high
//   rx          - serial line, idles high, asynchronous to clock
//   sink        - uart_rx_if master: out/put/rts driven, full sampled
//   frame_error - one-clock pulse, stop bit sampled low
//   overrun     - one-clock pulse, good byte dropped because full was high
// OVERSAMPLE must be even and at least 4.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      rx,
  uart_rx_if.master sink,
  output logic      frame_error,
  output logic      overrun
);

  localparam int CW = $clog2(OVERSAMPLE + 1);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE);
  localparam logic [BW-1:0] BI_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [BW-1:0]        bi, bi_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] out_q, out_n;
  logic                 put_q, put_n;
  logic                 fe_q, fe_n;
  logic                 ov_q, ov_n;
  logic                 rts_q;
  logic                 rx_meta, rxs;

  // Two-flop synchronizer.  Both flops reset high so that reset release
  // never looks like a falling edge on an idle line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // rts simply mirrors full one clock late.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rts_q <= 1'b1;
    end else begin
      rts_q <= sink.full;
    end
  end

  // State and datapath registers.  Reset throws away any frame in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      bi    <= '0;
      shift <= '0;
      out_q <= '0;
      put_q <= 1'b0;
      fe_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      bi    <= bi_n;
      shift <= shift_n;
      out_q <= out_n;
      put_q <= put_n;
      fe_q  <= fe_n;
      ov_q  <= ov_n;
    end
  end

  // Next-state logic.  cnt counts clocks inside the current bit.  The start
  // bit is checked at its middle; from then on each sample lands one full
  // bit period later, so every data and stop sample is also mid-bit.
  // Leaving STOP at mid stop bit lets a start bit that follows immediately
  // be caught.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bi_n    = bi;
    shift_n = shift;
    out_n   = out_q;
    put_n   = 1'b0;
    fe_n    = 1'b0;
    ov_n    = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          cnt_n   = CNT_ONE;
        end
      end

      START: begin
        if (cnt == CNT_HALF) begin
          if (!rxs) begin
            state_n = DATA;
            cnt_n   = CNT_ONE;
            bi_n    = '0;
          end else begin
            // Line went back high before mid start bit: a glitch.
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (cnt == CNT_FULL) begin
          // LSB arrives first, so shifting right from the MSB leaves the
          // byte in natural order once every bit has been sampled.
          shift_n                = shift >> 1;
          shift_n[DATA_BITS-1]   = rxs;
          cnt_n                  = CNT_ONE;
          bi_n                   = bi + BW'(1);
          if (bi == BI_LAST) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      STOP: begin
        if (cnt == CNT_FULL) begin
          if (rxs) begin
            if (sink.full) begin
              ov_n = 1'b1;
            end else begin
              out_n = shift;
              put_n = 1'b1;
            end
            state_n = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = BREAK;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end

      BREAK: begin
        // A held-low line must go high before a new start bit is accepted.
        if (rxs) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign sink.out    = out_q;
  assign sink.put    = put_q;
  assign sink.rts    = rts_q;
  assign frame_error = fe_q;
  assign overrun     = ov_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.  Frames are driven onto rx
// at OVERSAMPLE clocks per bit.  A reference model decides what each frame
// should produce (byte, overrun or framing error) from its stop bit and the
// level of full.  A monitor compares every strobe against that model.
module tb_uart_rx;

  localparam int OS = 16;
  localparam int DB = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;
  logic frame_error;
  logic overrun;

  uart_rx_if #(.DATA_BITS(DB)) sink_if ();

  uart_rx #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .sink        (sink_if.master),
    .frame_error (frame_error),
    .overrun     (overrun)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int n_put = 0;
  int n_fe  = 0;
  int n_ov  = 0;
  int last_put_cyc = -1;

  int exp_put = 0;
  int exp_fe  = 0;
  int exp_ov  = 0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] exp_out = '0;

  // Free-running clock count used to time the first byte.
  always @(posedge clock) cyc <= cyc + 1;

  // Counts one comparison and reports it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Reference model: the outcome of a frame depends only on its stop bit
  // and on the level of full while it is being received.
  task automatic expectFrame(input logic [DB-1:0] data, input logic stop_bit, input logic full_v);
    if (!stop_bit) begin
      exp_fe++;
    end else if (full_v) begin
      exp_ov++;
    end else begin
      exp_put++;
      exp_q.push_back(data);
      exp_out = data;
    end
  endtask

  // Drives one frame starting at a negedge.  rx is left at the stop level
  // so that a low stop bit continues as a break.
  task automatic applyStimulus(input logic [DB-1:0] data, input logic stop_bit);
    rx = 1'b0;
    repeat (OS) @(negedge clock);
    for (int i = 0; i < DB; i++) begin
      rx = data[i];
      repeat (OS) @(negedge clock);
    end
    rx = stop_bit;
    repeat (OS) @(negedge clock);
  endtask

  task automatic sendFrame(input logic [DB-1:0] data, input logic stop_bit);
    expectFrame(data, stop_bit, sink_if.full);
    applyStimulus(data, stop_bit);
  endtask

  task automatic idleBits(input int n);
    rx = 1'b1;
    repeat (n * OS) @(negedge clock);
  endtask

  task automatic checkCounts(input string phase);
    checkOutput({phase, "_puts"}, 32'(n_put), 32'(exp_put));
    checkOutput({phase, "_frame_errors"}, 32'(n_fe), 32'(exp_fe));
    checkOutput({phase, "_overruns"}, 32'(n_ov), 32'(exp_ov));
  endtask

  // Strobe monitor: each strobe seen high on a negedge is one event.  A
  // strobe stuck high would be counted repeatedly and break the totals.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (sink_if.put || frame_error || overrun) begin
          checkOutput("strobe_exclusive",
                      32'(sink_if.put) + 32'(frame_error) + 32'(overrun), 32'd1);
        end
        if (sink_if.put) begin
          n_put++;
          last_put_cyc = cyc;
          if (exp_q.size() == 0) begin
            checkOutput("put_expected", 32'(exp_q.size()), 32'd1);
          end else begin
            checkOutput("put_data", 32'(sink_if.out), 32'(exp_q.pop_front()));
          end
        end
        if (frame_error) n_fe++;
        if (overrun)     n_ov++;
      end
    end
  end

  logic [DB-1:0] stream [7] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h0D, 8'h0A};
  logic [DB-1:0] abort_byte;
  logic [DB-1:0] rnd_byte;
  logic          rnd_stop;
  int            start_cyc;
  int            lat;

  initial begin
    sink_if.full = 1'b0;
    rx           = 1'b1;
    reset        = 1'b1;
    repeat (3) @(negedge clock);

    $display("[TB] reset values");
    checkOutput("rst_put", 32'(sink_if.put), 32'd0);
    checkOutput("rst_frame_error", 32'(frame_error), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_out", 32'(sink_if.out), 32'd0);
    checkOutput("rst_rts", 32'(sink_if.rts), 32'd1);
    reset = 1'b0;
    @(negedge clock);
    idleBits(1);
    checkOutput("rts_idle_low", 32'(sink_if.rts), 32'd0);

    $display("[TB] single byte");
    start_cyc = cyc;
    sendFrame(8'h48, 1'b1);
    idleBits(2);
    // 152 clocks after detection plus 2-3 clocks of synchronizer delay.
    lat = last_put_cyc - start_cyc;
    checkOutput("single_latency_window", 32'(lat >= 154 && lat <= 156), 32'd1);
    checkOutput("single_out", 32'(sink_if.out), 32'h48);
    checkCounts("single");

    $display("[TB] back-to-back stream");
    foreach (stream[i]) sendFrame(stream[i], 1'b1);
    idleBits(2);
    checkCounts("stream");
    checkOutput("stream_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] start-bit glitch");
    rx = 1'b0;
    repeat (4) @(negedge clock);
    idleBits(2);
    checkCounts("glitch");
    sendFrame(8'h55, 1'b1);
    idleBits(2);
    checkOutput("glitch_next_out", 32'(sink_if.out), 32'h55);
    checkCounts("glitch_next");

    $display("[TB] framing error and break");
    sendFrame(8'hA5, 1'b0);
    repeat (40 * OS) @(negedge clock);
    idleBits(2);
    checkCounts("frame_err");
    checkOutput("frame_err_out_hold", 32'(sink_if.out), 32'h55);
    sendFrame(8'h3C, 1'b1);
    idleBits(2);
    checkOutput("after_break_out", 32'(sink_if.out), 32'h3C);
    checkCounts("after_break");

    $display("[TB] overrun and flow control");
    sink_if.full = 1'b1;
    #1;
    checkOutput("rts_before_edge", 32'(sink_if.rts), 32'd0);
    @(negedge clock);
    checkOutput("rts_after_full_rise", 32'(sink_if.rts), 32'd1);
    sendFrame(8'h61, 1'b1);
    idleBits(2);
    checkOutput("overrun_out_hold", 32'(sink_if.out), 32'(exp_out));
    checkCounts("overrun");
    sink_if.full = 1'b0;
    #1;
    checkOutput("rts_before_fall_edge", 32'(sink_if.rts), 32'd1);
    @(negedge clock);
    checkOutput("rts_after_full_fall", 32'(sink_if.rts), 32'd0);
    sendFrame(8'h61, 1'b1);
    idleBits(2);
    checkOutput("resend_out", 32'(sink_if.out), 32'h61);
    checkCounts("resend");

    $display("[TB] reset mid-frame");
    abort_byte = 8'h7E;
    rx = 1'b0;
    repeat (OS) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rx = abort_byte[i];
      repeat (OS) @(negedge clock);
    end
    rx = abort_byte[3];
    repeat (OS / 2) @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("abort_put", 32'(sink_if.put), 32'd0);
    checkOutput("abort_frame_error", 32'(frame_error), 32'd0);
    checkOutput("abort_overrun", 32'(overrun), 32'd0);
    checkOutput("abort_out", 32'(sink_if.out), 32'd0);
    checkOutput("abort_rts", 32'(sink_if.rts), 32'd1);
    exp_out = '0;
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idleBits(12);
    checkCounts("abort");
    checkOutput("abort_out_after", 32'(sink_if.out), 32'd0);
    sendFrame(8'h7E, 1'b1);
    idleBits(2);
    checkOutput("fresh_out", 32'(sink_if.out), 32'h7E);
    checkCounts("fresh");

    $display("[TB] randomized frames");
    for (int n = 0; n < 24; n++) begin
      sink_if.full = ($urandom_range(0, 3) == 0);
      rnd_byte     = 8'($urandom);
      rnd_stop     = ($urandom_range(0, 5) != 0);
      sendFrame(rnd_byte, rnd_stop);
      if (!rnd_stop) begin
        repeat ($urandom_range(1, 5) * OS) @(negedge clock);
        idleBits($urandom_range(1, 2));
      end else begin
        idleBits($urandom_range(0, 2));
      end
    end
    sink_if.full = 1'b0;
    idleBits(2);
    checkCounts("random");
    checkOutput("random_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("random_out_last", 32'(sink_if.out), 32'(exp_out));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
